// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS commit-trace buffer: FSM state encoding and trace entry layout.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_entry_t;

    // The listed fields add up to 102 bits, so the width is taken from the struct itself.
    localparam int unsigned ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO. Flush beats push/pop; a pop on a full FIFO lets the same-edge
// push through. Head data reads as zero while empty.
module trace_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ENTRY_W = 102
) (
    input  logic                     CPUCLK,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [ENTRY_W-1:0]       wdata_i,
    output logic [ENTRY_W-1:0]       rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               do_push, do_pop;

    // Accept/pop decisions and next pointer/occupancy values.
    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == (AW + 1)'(DEPTH));
        do_pop   = pop_i & ~empty_o & ~flush_i;
        do_push  = push_i & (~full_o | do_pop) & ~flush_i;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW + 1)'(1);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
        count_o = count_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CPUCLK or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written since reads are masked by empty.
    always_ff @(posedge CPUCLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mips_commit_trace.sv
// Commit-trace capture: arms on command, optionally waits for a PC trigger, then records
// retiring instructions into a FIFO drained by a valid/ready reader.
module mips_commit_trace
    import mips_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 7
) (
    input  logic          CPUCLK,
    input  logic          reset,
    input  logic [31:0]   commit_pc_i,
    input  logic [31:0]   commit_instr_i,
    input  logic          commit_we_i,
    input  logic [4:0]    commit_waddr_i,
    input  logic [31:0]   commit_wdata_i,
    input  logic          arm_i,
    input  logic          trig_en_i,
    input  logic [31:0]   trig_pc_i,
    input  logic [CW-1:0] capture_len_i,
    input  logic          rd_ready_i,
    output logic          rd_valid_o,
    output logic [31:0]   rd_pc_o,
    output logic [31:0]   rd_instr_o,
    output logic          rd_we_o,
    output logic [4:0]    rd_waddr_o,
    output logic [31:0]   rd_wdata_o,
    output logic [1:0]    state_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    trace_state_e  state_q, state_d;
    logic [CW-1:0] captured_q, captured_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] cap_next;
    logic          want_write, flush;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   fifo_count;
    trace_entry_t  wr_entry, rd_entry;

    assign wr_entry = '{pc: commit_pc_i, instr: commit_instr_i, we: commit_we_i,
                        waddr: commit_waddr_i, wdata: commit_wdata_i};

    // Capture FSM, trigger compare, captured counter and sticky overflow.
    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        overflow_d = overflow_q;
        want_write = 1'b0;
        flush      = 1'b0;
        cap_next   = captured_q + CW'(1);
        if (arm_i) begin
            flush      = 1'b1;
            overflow_d = 1'b0;
            captured_d = '0;
            state_d    = trig_en_i ? ARMED : CAPTURE;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (commit_pc_i == trig_pc_i) begin
                        want_write = 1'b1;
                        captured_d = CW'(1);
                        state_d    = (capture_len_i == CW'(1)) ? DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    want_write = 1'b1;
                    captured_d = cap_next;
                    if (capture_len_i != '0 && cap_next == capture_len_i) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
            // A same-edge pop frees the slot, so only a full FIFO without a read drops.
            if (want_write && fifo_full && !(rd_ready_i && !fifo_empty)) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge CPUCLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            captured_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .CPUCLK  (CPUCLK),
        .reset   (reset),
        .push_i  (want_write),
        .pop_i   (rd_ready_i),
        .flush_i (flush),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Reader-facing outputs; FIFO already zeroes the head while empty.
    always_comb begin
        rd_valid_o = ~fifo_empty;
        rd_pc_o    = rd_entry.pc;
        rd_instr_o = rd_entry.instr;
        rd_we_o    = rd_entry.we;
        rd_waddr_o = rd_entry.waddr;
        rd_wdata_o = rd_entry.wdata;
        state_o    = state_q;
        count_o    = CW'(fifo_count);
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_mips_commit_trace.sv
// Bench for mips_commit_trace: vector table, directed corner sequences and a random run,
// all compared against a queue-based reference model.
module tb_mips_commit_trace;

    localparam int DEPTH = 16;
    localparam int CW    = 7;

    logic          CPUCLK;
    logic          reset;
    logic [31:0]   commit_pc, commit_instr, commit_wdata, trig_pc;
    logic          commit_we, arm, trig_en, rd_ready;
    logic [4:0]    commit_waddr;
    logic [CW-1:0] capture_len;
    logic          rd_valid, rd_we, overflow;
    logic [31:0]   rd_pc, rd_instr, rd_wdata;
    logic [4:0]    rd_waddr;
    logic [1:0]    state;
    logic [CW-1:0] count;

    int nchecks = 0;
    int nerrors = 0;

    mips_commit_trace #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CPUCLK         (CPUCLK),
        .reset          (reset),
        .commit_pc_i    (commit_pc),
        .commit_instr_i (commit_instr),
        .commit_we_i    (commit_we),
        .commit_waddr_i (commit_waddr),
        .commit_wdata_i (commit_wdata),
        .arm_i          (arm),
        .trig_en_i      (trig_en),
        .trig_pc_i      (trig_pc),
        .capture_len_i  (capture_len),
        .rd_ready_i     (rd_ready),
        .rd_valid_o     (rd_valid),
        .rd_pc_o        (rd_pc),
        .rd_instr_o     (rd_instr),
        .rd_we_o        (rd_we),
        .rd_waddr_o     (rd_waddr),
        .rd_wdata_o     (rd_wdata),
        .state_o        (state),
        .count_o        (count),
        .overflow_o     (overflow)
    );

    initial CPUCLK = 1'b0;
    always #5 CPUCLK = ~CPUCLK;

    // Reference model: FIFO as a queue of records, state as an int 0..3.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ent_t;

    ent_t m_q[$];
    int   m_state;
    int   m_cap;
    bit   m_ovf;

    function automatic void model_reset();
        m_q.delete();
        m_state = 0;
        m_cap   = 0;
        m_ovf   = 0;
    endfunction

    function automatic void model_edge();
        bit   do_write;
        bit   do_pop;
        ent_t e;
        if (arm) begin
            m_q.delete();
            m_ovf   = 0;
            m_cap   = 0;
            m_state = trig_en ? 1 : 2;
            return;
        end
        do_pop   = rd_ready && (m_q.size() > 0);
        do_write = 0;
        if (m_state == 1) begin
            if (commit_pc == trig_pc) begin
                do_write = 1;
                m_cap    = 1;
                m_state  = (int'(capture_len) == 1) ? 3 : 2;
            end
        end else if (m_state == 2) begin
            do_write = 1;
            m_cap    = (m_cap + 1) % (1 << CW);
            if (capture_len != 0 && m_cap == int'(capture_len)) m_state = 3;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_write) begin
            e.pc = commit_pc; e.instr = commit_instr; e.we = commit_we;
            e.waddr = commit_waddr; e.wdata = commit_wdata;
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else m_ovf = 1;
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        ent_t h;
        h = '{pc: 0, instr: 0, we: 0, waddr: 0, wdata: 0};
        if (m_q.size() > 0) h = m_q[0];
        chk("state", 64'(state), 64'(m_state));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("rd_valid", 64'(rd_valid), 64'(m_q.size() > 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("rd_pc", 64'(rd_pc), 64'(h.pc));
        chk("rd_instr", 64'(rd_instr), 64'(h.instr));
        chk("rd_we", 64'(rd_we), 64'(h.we));
        chk("rd_waddr", 64'(rd_waddr), 64'(h.waddr));
        chk("rd_wdata", 64'(rd_wdata), 64'(h.wdata));
    endtask

    // One CPUCLK edge with the currently driven inputs.
    task automatic step();
        model_edge();
        @(posedge CPUCLK);
        #1;
        compare_model();
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd);
        commit_pc    = pc;
        commit_instr = pc ^ 32'hdead_0000;
        commit_we    = we;
        commit_waddr = wa;
        commit_wdata = wd;
    endtask

    task automatic do_arm(input logic te, input logic [31:0] tp, input logic [CW-1:0] len);
        arm = 1; trig_en = te; trig_pc = tp; capture_len = len;
        step();
        arm = 0;
    endtask

    typedef struct {
        logic          arm;
        logic          te;
        logic [31:0]   tp;
        logic [CW-1:0] len;
        logic [31:0]   pc;
        logic          rdy;
        logic [1:0]    exp_state;
        logic [CW-1:0] exp_count;
        logic          exp_valid;
        logic [31:0]   exp_head;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic a, input logic te, input logic [31:0] tp,
                                input int len, input logic [31:0] pc, input logic rdy,
                                input int st, input int cnt, input logic v,
                                input logic [31:0] head);
        vec_t r;
        r.arm = a; r.te = te; r.tp = tp; r.len = CW'(len); r.pc = pc; r.rdy = rdy;
        r.exp_state = 2'(st); r.exp_count = CW'(cnt); r.exp_valid = v; r.exp_head = head;
        tbl.push_back(r);
    endfunction

    initial begin
        int rd_bias;
        reset = 1; arm = 0; trig_en = 0; trig_pc = 0; capture_len = 0; rd_ready = 0;
        set_commit(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge CPUCLK);
        #1;
        chk("reset_state", 64'(state), 0);
        chk("reset_count", 64'(count), 0);
        chk("reset_valid", 64'(rd_valid), 0);
        chk("reset_ovf", 64'(overflow), 0);
        chk("reset_rd_pc", 64'(rd_pc), 0);
        reset = 0;

        // Immediate capture of 4, then trigger at 0x20 for 3, then drain.
        add(1, 0, 0, 4, 32'h00, 0, 2, 0, 0, 0);
        add(0, 0, 0, 4, 32'h00, 0, 2, 1, 1, 32'h00);
        add(0, 0, 0, 4, 32'h04, 0, 2, 2, 1, 32'h00);
        add(0, 0, 0, 4, 32'h08, 0, 2, 3, 1, 32'h00);
        add(0, 0, 0, 4, 32'h0C, 0, 3, 4, 1, 32'h00);
        add(0, 0, 0, 4, 32'h10, 0, 3, 4, 1, 32'h00);
        add(1, 1, 32'h20, 3, 32'h00, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 32'h20, 3, 32'(4 * i), 0, 1, 0, 0, 0);
        add(0, 1, 32'h20, 3, 32'h20, 0, 2, 1, 1, 32'h20);
        add(0, 1, 32'h20, 3, 32'h24, 0, 2, 2, 1, 32'h20);
        add(0, 1, 32'h20, 3, 32'h28, 0, 3, 3, 1, 32'h20);
        add(0, 1, 32'h20, 3, 32'h2C, 0, 3, 3, 1, 32'h20);
        add(0, 1, 32'h20, 3, 32'h30, 1, 3, 2, 1, 32'h24);
        add(0, 1, 32'h20, 3, 32'h34, 1, 3, 1, 1, 32'h28);
        add(0, 1, 32'h20, 3, 32'h38, 1, 3, 0, 0, 32'h00);
        add(0, 1, 32'h20, 3, 32'h3C, 1, 3, 0, 0, 32'h00);
        for (int i = 0; i < tbl.size(); i++) begin
            arm = tbl[i].arm; trig_en = tbl[i].te; trig_pc = tbl[i].tp;
            capture_len = tbl[i].len; rd_ready = tbl[i].rdy;
            set_commit(tbl[i].pc, 0, 0, 0);
            step();
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(tbl[i].exp_state));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].exp_count));
            chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_head", i), 64'(rd_pc), 64'(tbl[i].exp_head));
        end
        arm = 0; rd_ready = 0;

        // Overflow: 20 commits into 16 slots, oldest retained, then drain all 16.
        do_arm(0, 0, 20);
        for (int i = 0; i < 20; i++) begin
            set_commit(32'h100 + 32'(4 * i), 0, 0, 0);
            step();
        end
        chk("ovf_count", 64'(count), 16);
        chk("ovf_flag", 64'(overflow), 1);
        chk("ovf_state", 64'(state), 3);
        chk("ovf_head", 64'(rd_pc), 64'h100);
        rd_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_drain%0d", i), 64'(rd_pc), 64'(32'h100 + 32'(4 * i)));
            step();
        end
        chk("ovf_drained", 64'(rd_valid), 0);
        rd_ready = 0;

        // Full FIFO with simultaneous read: write accepted, no overflow, new pc at tail.
        do_arm(0, 0, 17);
        for (int i = 0; i < 16; i++) begin
            set_commit(32'h400 + 32'(4 * i), 0, 0, 0);
            step();
        end
        chk("full_count", 64'(count), 16);
        rd_ready = 1;
        set_commit(32'h500, 0, 0, 0);
        step();
        chk("fullrd_count", 64'(count), 16);
        chk("fullrd_ovf", 64'(overflow), 0);
        chk("fullrd_head", 64'(rd_pc), 64'h404);
        for (int i = 0; i < 15; i++) step();
        chk("fullrd_tail", 64'(rd_pc), 64'h500);
        step();
        chk("fullrd_empty", 64'(rd_valid), 0);
        rd_ready = 0;

        // Writeback fields of a jal at 0x40, captured by trigger with length 1.
        do_arm(1, 32'h40, 1);
        set_commit(32'h3C, 0, 0, 0);
        step();
        chk("jal_armed", 64'(state), 1);
        set_commit(32'h40, 1, 5'd31, 32'h44);
        step();
        chk("jal_state", 64'(state), 3);
        chk("jal_we", 64'(rd_we), 1);
        chk("jal_waddr", 64'(rd_waddr), 31);
        chk("jal_wdata", 64'(rd_wdata), 64'h44);

        // Asynchronous reset mid-capture, then a fresh capture.
        do_arm(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            set_commit(32'h600 + 32'(4 * i), 0, 0, 0);
            step();
        end
        chk("pre_reset_count", 64'(count), 5);
        reset = 1;
        #1;
        chk("mid_reset_count", 64'(count), 0);
        chk("mid_reset_state", 64'(state), 0);
        chk("mid_reset_valid", 64'(rd_valid), 0);
        model_reset();
        #2 reset = 0;
        do_arm(0, 0, 2);
        set_commit(32'h700, 0, 0, 0);
        step();
        set_commit(32'h704, 0, 0, 0);
        step();
        chk("rearm_count", 64'(count), 2);
        chk("rearm_head", 64'(rd_pc), 64'h700);

        // Randomized run against the model.
        rd_bias = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) rd_bias = (i / 150) % 3 == 0 ? 10 : ((i / 150) % 3 == 1 ? 90 : 50);
            arm = ($urandom_range(0, 24) == 0);
            if (arm) begin
                trig_en     = 1'($urandom_range(0, 1));
                trig_pc     = 32'(4 * $urandom_range(0, 15));
                capture_len = CW'($urandom_range(0, 20));
            end
            set_commit(32'(4 * $urandom_range(0, 15)), 1'($urandom), 5'($urandom), $urandom);
            commit_instr = $urandom;
            rd_ready = ($urandom_range(0, 99) < rd_bias);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
